barrel_shift_arbiter: RTL and testbench
=======================================

// Module: barrel_shift_arbiter
// PURPOSE
//  Shares one barrel_shifter instance between two requesters (REQ0, REQ1) over valid/ready handshakes.
//  - Round-robin arbitration; the winning request drives the shifter.
//  - Result is registered and returned on a single valid/ready output port, tagged with the winner's ID.
//  - Sits between the two issuing blocks and the shared shifter datapath.
// PARAMETERS
//  DATA_WIDTH  8  operand/result width; must match barrel_shifter data_width
//  SHIFT_W     3  shift-amount width; must equal clog2(DATA_WIDTH)
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous reset, active-high
//  req0_valid  in   1           requester 0 has an operation
//  req0_ready  out  1           requester 0 operation accepted this cycle
//  req0_data   in   DATA_WIDTH  requester 0 operand
//  req0_dir    in   1           0 = left, 1 = right (drives left_right_sel)
//  req0_shift  in   SHIFT_W     requester 0 shift amount
//  req1_*      -    -           identical set of ports for requester 1
//  out_valid   out  1           result register holds a valid result
//  out_ready   in   1           downstream accepts the result
//  out_data    out  DATA_WIDTH  shifted result
//  out_id      out  1           ID of the requester that issued the result
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_id=0, req0_ready=req1_ready=0, rr_ptr=0.
//    Reset mid-operation discards the held result and any pending grant.
//  - Shift semantics: logical shift with zero fill, as performed by barrel_shifter.
//    Shift amount 0 passes data through unchanged.
//  - can_accept = !out_valid || out_ready.
//  - Arbitration (combinational, same cycle):
//    - Only REQ0 valid -> grant 0. Only REQ1 valid -> grant 1.
//    - Both valid -> grant rr_ptr.
//    - reqN_ready = can_accept && grant==N && reqN_valid; at most one ready is high per cycle.
//  - Mux: the granted requester's data/dir/shift drive the barrel_shifter inputs.
//    With no grant, the shifter inputs hold 0.
//  - Accept (reqN_valid && reqN_ready at edge):
//    - out_data <= shifter output; out_id <= N; out_valid <= 1; rr_ptr <= ~N.
//    - Latency: result visible on out_* the cycle after the accepting edge.
//  - Output drains (out_valid && out_ready) with no accept in the same edge -> out_valid <= 0.
//  - Simultaneous drain and accept at one edge: the new result replaces the old.
//    out_valid stays 1, giving full throughput of one op per cycle.
//  - Backpressure: while out_valid && !out_ready, both readies are 0.
//    out_data and out_id hold stable.
//  - rr_ptr changes only on an accept. A lone requester never advances fairness against itself.
//  - FSM, 2 states:
//    - EMPTY (out_valid=0): accept -> FULL; otherwise stay EMPTY.
//    - FULL (out_valid=1): drain without accept -> EMPTY; drain with accept -> FULL; no drain -> FULL.
//  - Requesters may drop valid without being granted; no request is latched before grant.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0; release rst with no valids -> outputs stay 0.
//  2. REQ0 data=0xF0 dir=0 shift=4, out_ready=1:
//     req0_ready=1 in the same cycle; next cycle out_valid=1, out_data=0x00, out_id=0.
//  3. REQ1 data=0xF0 dir=1 shift=1 -> next cycle out_data=0x78, out_id=1.
//     Shift 0 with data=0xA5 -> out_data=0xA5.
//  4. Both requesters valid continuously, out_ready=1:
//     grants alternate 0,1,0,1; out_id alternates; one result per cycle.
//  5. Hold out_ready=0 with a result held:
//     both readies 0; out_data and out_id stable 5 cycles; raise out_ready -> drain and accept on the same edge.
//  6. Assert rst while out_valid=1 and both requesters valid -> next cycle out_valid=0, rr_ptr=0.
//     The first grant after reset goes to REQ0.

Source files
------------

// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin front end for a shared logical barrel shifter.
// The granted operation is shifted combinationally and its result is held in a one-entry output register.
module barrel_shift_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_dir,
    input  logic [SHIFT_W-1:0]    req0_shift,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_dir,
    input  logic [SHIFT_W-1:0]    req1_shift,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_id
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Ready never waits on a later valid; valid may drop at any time before it is granted.

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_id_q, out_id_d;

    logic                  can_accept;
    logic                  grant_valid;
    logic                  grant_id;
    logic                  accept;
    logic                  drain;

    logic [DATA_WIDTH-1:0] sh_data_in;
    logic                  sh_dir;
    logic [SHIFT_W-1:0]    sh_amt;
    logic [DATA_WIDTH-1:0] sh_data_out;

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

    // Readies are gated by rst so nothing can be accepted on the reset edge.
    always_comb begin
        can_accept  = !out_valid || out_ready;
        grant_valid = req0_valid || req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = rr_ptr_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        req0_ready = !rst && can_accept && grant_valid && (grant_id == 1'b0) && req0_valid;
        req1_ready = !rst && can_accept && grant_valid && (grant_id == 1'b1) && req1_valid;
        accept     = req0_ready || req1_ready;
        drain      = out_valid && out_ready;
    end

    always_comb begin
        sh_data_in = '0;
        sh_dir     = 1'b0;
        sh_amt     = '0;
        if (grant_valid) begin
            if (grant_id) begin
                sh_data_in = req1_data;
                sh_dir     = req1_dir;
                sh_amt     = req1_shift;
            end else begin
                sh_data_in = req0_data;
                sh_dir     = req0_dir;
                sh_amt     = req0_shift;
            end
        end
    end

    // Logarithmic shifter: stage i moves the word by 2**i when shift bit i is set, zero filling.
    always_comb begin : shifter
        logic [DATA_WIDTH-1:0] stage;
        stage = sh_data_in;
        for (int i = 0; i < SHIFT_W; i++) begin
            if (sh_amt[i]) begin
                if (sh_dir) begin
                    stage = stage >> (2 ** i);
                end else begin
                    stage = stage << (2 ** i);
                end
            end
        end
        sh_data_out = stage;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (drain && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A fresh result overwrites the register even when the old one drains on the same edge.
        if (accept) begin
            out_data_d = sh_data_out;
            out_id_d   = grant_id;
            rr_ptr_d   = ~grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rr_ptr_q   <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
        end
    end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed bench for barrel_shift_arbiter: a vector table for single-cycle behaviour
// and hand-written sequences for backpressure and reset during a held result.
module tb_barrel_shift_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, req0_dir;
    logic [7:0] req0_data;
    logic [2:0] req0_shift;
    logic       req1_valid, req1_ready, req1_dir;
    logic [7:0] req1_data;
    logic [2:0] req1_shift;
    logic       out_valid, out_ready, out_id;
    logic [7:0] out_data;

    int total;
    int bad;

    barrel_shift_arbiter #(.DATA_WIDTH(8), .SHIFT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_dir   (req0_dir),
        .req0_shift (req0_shift),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_dir   (req1_dir),
        .req1_shift (req1_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v0;
        logic [7:0] d0;
        logic       dir0;
        logic [2:0] sh0;
        logic       v1;
        logic [7:0] d1;
        logic       dir1;
        logic [2:0] sh1;
        logic       ordy;
        logic       exp_r0;
        logic       exp_r1;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic       exp_id;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic dir0, input logic [2:0] sh0,
                         input logic v1, input logic [7:0] d1, input logic dir1, input logic [2:0] sh1,
                         input logic ordy);
        req0_valid = v0; req0_data = d0; req0_dir = dir0; req0_shift = sh0;
        req1_valid = v1; req1_data = d1; req1_dir = dir1; req1_shift = sh1;
        out_ready  = ordy;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [7:0] od, input logic oid);
        check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
        check({tag, ".out_data"}, out_data, od);
        check({tag, ".out_id"}, {7'd0, out_id}, {7'd0, oid});
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        check({tag, ".req0_ready"}, {7'd0, req0_ready}, {7'd0, r0});
        check({tag, ".req1_ready"}, {7'd0, req1_ready}, {7'd0, r1});
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //           v0  d0     dr sh  v1  d1     dr sh  ordy r0 r1 ov od     id
        vecs[0]  = '{1'b1, 8'hF0, 1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 8'hF0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h78, 1'b1};
        vecs[2]  = '{1'b1, 8'hA5, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[4]  = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b1, 8'h80, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1};
        vecs[5]  = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b1, 8'h80, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0};
        vecs[6]  = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b1, 8'h80, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1};
        vecs[7]  = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b1, 8'h80, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h3C, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b1};
        vecs[9]  = '{1'b1, 8'h81, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
        vecs[10] = '{1'b1, 8'hFF, 1'b0, 3'd7, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0};
        vecs[11] = '{1'b1, 8'h55, 1'b0, 3'd1, 1'b1, 8'h55, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b1};
        vecs[12] = '{1'b1, 8'h55, 1'b0, 3'd1, 1'b1, 8'h55, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 1'b1};

        // Reset held for two cycles, then released with nothing requested.
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00, 1'b0);
        check_ready("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("idle", 1'b0, 8'h00, 1'b0);
        check_ready("idle", 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].d0, vecs[i].dir0, vecs[i].sh0,
                  vecs[i].v1, vecs[i].d1, vecs[i].dir1, vecs[i].sh1, vecs[i].ordy);
            #1;
            check_ready($sformatf("vec%0d", i), vecs[i].exp_r0, vecs[i].exp_r1);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_id);
        end

        // Backpressure: result 0x2A from REQ1 must hold while both requesters wait.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b1, 8'h0F, 1'b0, 3'd4, 1'b1, 8'hC3, 1'b1, 3'd3, 1'b0);
            #1;
            check_ready($sformatf("stall%0d", c), 1'b0, 1'b0);
            @(posedge clk);
            #1;
            check_out($sformatf("stall%0d", c), 1'b1, 8'h2A, 1'b1);
        end

        // Release: drain and accept on one edge; rr_ptr points at REQ0.
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_ready("release", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out("release", 1'b1, 8'hF0, 1'b0);

        // Reset while a result is held and both requesters are active.
        @(negedge clk);
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check_out("midrst", 1'b0, 8'h00, 1'b0);
        check_ready("midrst", 1'b0, 1'b0);

        // rr_ptr is 0 again, so REQ0 wins even though REQ1 would have been next.
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check_ready("postrst", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out("postrst", 1'b1, 8'hF0, 1'b0);

        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        @(posedge clk);
        #1;
        check_out("final_drain", 1'b0, 8'hF0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
